systolic_feed_ctrl: RTL and testbench

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

---
 rtl/systolic_feed_ctrl_pkg.sv | 17 +
 rtl/systolic_feed_ctrl_if.sv | 37 +++
 rtl/feed_skew_reg.sv | 76 +++++++
 rtl/systolic_feed_ctrl.sv | 127 ++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared definitions for the systolic operand feed controller.
//   DefaultDataW / DefaultAddrW : default operand and RAM address widths
//   state_e                     : controller FSM state encoding
package systolic_feed_ctrl_pkg;

   localparam int unsigned DefaultDataW = 16;
   localparam int unsigned DefaultAddrW = 4;

   typedef enum logic [2:0] {
      StIdle,
      StRead0,
      StRead1,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Synchronous single-port RAM bus between the feed controller and its operand RAM.
//   ram_en   : access enable (read or write)
//   ram_we   : write enable, qualified by ram_en
//   ram_addr : word address
//   ram_di   : write data
//   ram_do   : registered read data, valid the cycle after a read access
// modport master: controller side; modport slave: RAM side.
interface systolic_feed_ctrl_if
   import systolic_feed_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned ADDR_W = DefaultAddrW
) ();

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_di;
   logic [DATA_W-1:0] ram_do;

   modport master (
      output ram_en,
      output ram_we,
      output ram_addr,
      output ram_di,
      input  ram_do
   );

   modport slave (
      input  ram_en,
      input  ram_we,
      input  ram_addr,
      input  ram_di,
      output ram_do
   );

endinterface

// File: rtl/feed_skew_reg.sv
// Output skew registers for the 2x2 array feed.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : clear the row-1 hold register (new stream accepted)
//   beat_i       : data_i is row0[k]; load feed0 from it and feed1 from the hold register
//   hold_i       : data_i is row1[k-1]; capture it in the hold register
//   drain_i      : final beat; feed0 gets zero, feed1 (and hold) get data_i = row1[len-1]
//   data_i       : RAM read data
//   feed0_o/1_o  : row-0 / row-1 operands presented to the array
//   feed_valid_o : feed0_o/feed1_o carry a beat this cycle
module feed_skew_reg
   import systolic_feed_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              beat_i,
   input  logic              hold_i,
   input  logic              drain_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] feed0_o,
   output logic [DATA_W-1:0] feed1_o,
   output logic              feed_valid_o
);

   logic [DATA_W-1:0] feed0_q, feed0_d;
   logic [DATA_W-1:0] feed1_q, feed1_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              valid_q, valid_d;

   always_comb begin
      feed0_d = feed0_q;
      feed1_d = feed1_q;
      hold_d  = hold_q;
      valid_d = 1'b0;
      // Hold starts at zero so the first beat inserts 0 on row 1.
      if (clr_i) begin
         hold_d = '0;
      end
      if (beat_i) begin
         feed0_d = data_i;
         feed1_d = hold_q;
         valid_d = 1'b1;
      end
      if (hold_i) begin
         hold_d = data_i;
      end
      // Last row-1 word goes straight to feed1 while row 0 is zero-filled.
      if (drain_i) begin
         feed0_d = '0;
         feed1_d = data_i;
         hold_d  = data_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         feed0_q <= '0;
         feed1_q <= '0;
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         feed0_q <= feed0_d;
         feed1_q <= feed1_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
      end
   end

   assign feed0_o      = feed0_q;
   assign feed1_o      = feed1_q;
   assign feed_valid_o = valid_q;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Streams a 2xK operand matrix from a single-port RAM into a 2x2 systolic array, with row 1
// skewed one beat behind row 0. Row 0 lives at base+k, row 1 at base+len+k (addresses wrap).
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle stream request (ignored while a stream runs)
//   base_addr, len      : row-0 start address and K, sampled on an accepted start
//   host_we/addr/di     : host RAM write, honoured only when idle and not starting
//   busy                : stream in progress or start asserted
//   ram                 : RAM bus (master)
//   feed_valid/0/1      : operand beat for the array
//   done                : one-cycle pulse at stream end
module systolic_feed_ctrl
   import systolic_feed_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned ADDR_W = DefaultAddrW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W-1:0]     len,
   input  logic                  host_we,
   input  logic [ADDR_W-1:0]     host_addr,
   input  logic [DATA_W-1:0]     host_di,
   output logic                  busy,
   systolic_feed_ctrl_if.master  ram,
   output logic                  feed_valid,
   output logic [DATA_W-1:0]     feed0,
   output logic [DATA_W-1:0]     feed1,
   output logic                  done
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] k_next;
   logic [ADDR_W-1:0] row0_addr;
   logic [ADDR_W-1:0] row1_addr;
   logic              accept;

   // Address arithmetic truncates to ADDR_W, giving the wrap-around layout.
   assign k_next    = k_q + 1'b1;
   assign row0_addr = base_q + k_q;
   assign row1_addr = base_q + len_q + k_q;

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      base_d       = base_q;
      len_d        = len_q;
      accept       = 1'b0;
      ram.ram_en   = 1'b0;
      ram.ram_we   = 1'b0;
      ram.ram_addr = '0;
      ram.ram_di   = '0;
      unique case (state_q)
         StIdle: begin
            // Start has priority over a host write in the same cycle.
            if (start) begin
               accept  = 1'b1;
               base_d  = base_addr;
               len_d   = len;
               k_d     = '0;
               state_d = (len == '0) ? StDone : StRead0;
            end else if (host_we) begin
               ram.ram_en   = 1'b1;
               ram.ram_we   = 1'b1;
               ram.ram_addr = host_addr;
               ram.ram_di   = host_di;
            end
         end
         StRead0: begin
            ram.ram_en   = 1'b1;
            ram.ram_addr = row0_addr;
            state_d      = StRead1;
         end
         StRead1: begin
            ram.ram_en   = 1'b1;
            ram.ram_addr = row1_addr;
            if (k_next < len_q) begin
               k_d     = k_next;
               state_d = StRead0;
            end else begin
               state_d = StDrain;
            end
         end
         StDrain: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         k_q     <= '0;
         base_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         base_q  <= base_d;
         len_q   <= len_d;
      end
   end

   assign busy = (state_q != StIdle) || start;
   assign done = (state_q == StDone);

   // In READ0 for k>0 the RAM returns row1[k-1] requested by the previous READ1.
   feed_skew_reg #(
      .DATA_W (DATA_W)
   ) u_skew (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (accept),
      .beat_i       (state_q == StRead1),
      .hold_i       ((state_q == StRead0) && (k_q != '0)),
      .drain_i      (state_q == StDrain),
      .data_i       (ram.ram_do),
      .feed0_o      (feed0),
      .feed1_o      (feed1),
      .feed_valid_o (feed_valid)
   );

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl with a behavioural synchronous RAM.
module tb_systolic_feed_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  base_addr;
   logic [3:0]  len;
   logic        host_we;
   logic [3:0]  host_addr;
   logic [15:0] host_di;
   logic        busy;
   logic        feed_valid;
   logic [15:0] feed0;
   logic [15:0] feed1;
   logic        done;

   systolic_feed_ctrl_if ram_if ();

   systolic_feed_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .len        (len),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_di    (host_di),
      .busy       (busy),
      .ram        (ram_if),
      .feed_valid (feed_valid),
      .feed0      (feed0),
      .feed1      (feed1),
      .done       (done)
   );

   // Behavioural RAM with registered read data.
   logic [15:0] mem [16];
   logic [15:0] rdata;
   always @(posedge clk) begin
      if (ram_if.ram_en) begin
         if (ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_di;
         else rdata <= mem[ram_if.ram_addr];
      end
   end
   assign ram_if.ram_do = rdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int addr_q[$], f0_q[$], f1_q[$], bc_q[$];
   int ea[$], e0[$], e1[$], ec[$];
   int done_cyc;
   int we_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic host_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      host_we = 1'b1; host_addr = a; host_di = d;
      #1;
      check_eq($sformatf("hw_we_%0d", a), {31'd0, ram_if.ram_we}, 32'd1);
      check_eq($sformatf("hw_addr_%0d", a), {28'd0, ram_if.ram_addr}, {28'd0, a});
      check_eq($sformatf("hw_di_%0d", a), {16'd0, ram_if.ram_di}, {16'd0, d});
   endtask

   // Pulse start, then log RAM addresses and beats per cycle (cycle 0 = first state after start).
   task automatic run_stream(input logic [3:0] b, input logic [3:0] l, input bit inj);
      addr_q.delete(); f0_q.delete(); f1_q.delete(); bc_q.delete();
      done_cyc = -1;
      we_cnt   = 0;
      @(negedge clk);
      start = 1'b1; base_addr = b; len = l;
      #1;
      check_eq("start_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 64; cyc++) begin
         if (ram_if.ram_en) addr_q.push_back(int'(ram_if.ram_addr));
         if (ram_if.ram_we) we_cnt++;
         if (feed_valid) begin
            f0_q.push_back(int'(feed0));
            f1_q.push_back(int'(feed1));
            bc_q.push_back(cyc);
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (inj && cyc == 1) begin
            start = 1'b1; base_addr = 4'd0; len = 4'd1;
         end
         if (inj && cyc == 2) start = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic compare_stream(input string tag, input int edone);
      check_eq({tag, "_done_cyc"}, done_cyc, edone);
      check_eq({tag, "_we_cnt"}, we_cnt, 0);
      check_eq({tag, "_n_addr"}, addr_q.size(), ea.size());
      for (int i = 0; i < ea.size(); i++)
         if (i < addr_q.size()) check_eq($sformatf("%s_addr%0d", tag, i), addr_q[i], ea[i]);
      check_eq({tag, "_n_beats"}, bc_q.size(), ec.size());
      for (int i = 0; i < ec.size(); i++) begin
         if (i < bc_q.size()) begin
            check_eq($sformatf("%s_beat%0d_cyc", tag, i), bc_q[i], ec[i]);
            check_eq($sformatf("%s_beat%0d_f0", tag, i), f0_q[i], e0[i]);
            check_eq($sformatf("%s_beat%0d_f1", tag, i), f1_q[i], e1[i]);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      rst_n = 1'b1; start = 1'b0; host_we = 1'b0;
      base_addr = '0; len = '0; host_addr = '0; host_di = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_valid", {31'd0, feed_valid}, 32'd0);
      check_eq("rst_feed0", {16'd0, feed0}, 32'd0);
      check_eq("rst_feed1", {16'd0, feed1}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_ram_en", {31'd0, ram_if.ram_en}, 32'd0);
      rst_n = 1'b1;

      // Preload through the host write path.
      host_write(4'd0, 16'h0000);  host_write(4'd1, 16'h0001);
      host_write(4'd2, 16'h0003);  host_write(4'd3, 16'h0000);
      host_write(4'd4, 16'h0002);  host_write(4'd5, 16'h0004);
      host_write(4'd6, 16'h1111);  host_write(4'd7, 16'h2222);
      host_write(4'd8, 16'h3333);  host_write(4'd9, 16'h4444);
      host_write(4'd14, 16'h0007); host_write(4'd15, 16'h0009);
      @(negedge clk);
      host_we = 1'b0; host_addr = 4'd9; host_di = 16'hFFFF;
      #1;
      check_eq("idle_ram_en", {31'd0, ram_if.ram_en}, 32'd0);
      check_eq("idle_ram_addr", {28'd0, ram_if.ram_addr}, 32'd0);
      check_eq("idle_ram_di", {16'd0, ram_if.ram_di}, 32'd0);

      // Basic 2x3 stream.
      run_stream(4'd0, 4'd3, 1'b0);
      ea = '{0, 3, 1, 4, 2, 5}; ec = '{2, 4, 6, 7};
      e0 = '{0, 1, 3, 0};       e1 = '{0, 0, 2, 4};
      compare_stream("k3", 7);

      // Address wrap-around.
      run_stream(4'd14, 4'd2, 1'b0);
      ea = '{14, 0, 15, 1}; ec = '{2, 4, 5};
      e0 = '{7, 9, 0};      e1 = '{0, 0, 1};
      compare_stream("wrap", 5);

      // Start pulsed mid-stream must be ignored.
      run_stream(4'd6, 4'd2, 1'b1);
      ea = '{6, 8, 7, 9};          ec = '{2, 4, 5};
      e0 = '{'h1111, 'h2222, 0};   e1 = '{0, 'h3333, 'h4444};
      compare_stream("ign", 5);

      // Empty stream.
      run_stream(4'd3, 4'd0, 1'b0);
      ea.delete(); ec.delete(); e0.delete(); e1.delete();
      compare_stream("len0", 0);

      // Host write colliding with start is dropped, then resubmitted after done.
      @(negedge clk);
      host_we = 1'b1; host_addr = 4'd5; host_di = 16'h00AA;
      start = 1'b1; base_addr = 4'd0; len = 4'd1;
      #1;
      check_eq("coll_busy", {31'd0, busy}, 32'd1);
      check_eq("coll_ram_we", {31'd0, ram_if.ram_we}, 32'd0);
      @(negedge clk);
      start = 1'b0; got = 1'b0; we_cnt = 0;
      for (int c = 0; c < 32; c++) begin
         if (ram_if.ram_we) we_cnt++;
         if (done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_eq("coll_done", {31'd0, got}, 32'd1);
      check_eq("coll_we_cnt", we_cnt, 0);
      check_eq("coll_mem_before", {16'd0, mem[5]}, 32'h0004);
      @(negedge clk);
      #1;
      check_eq("resub_busy", {31'd0, busy}, 32'd0);
      check_eq("resub_we", {31'd0, ram_if.ram_we}, 32'd1);
      check_eq("resub_addr", {28'd0, ram_if.ram_addr}, 32'd5);
      @(negedge clk);
      host_we = 1'b0;
      check_eq("resub_mem", {16'd0, mem[5]}, 32'h00AA);

      // Reset asserted during READ1 of the second element.
      @(negedge clk);
      start = 1'b1; base_addr = 4'd6; len = 4'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
      check_eq("pre_rst_addr", {28'd0, ram_if.ram_addr}, 32'd9);
      check_eq("pre_rst_feed0", {16'd0, feed0}, 32'h1111);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
      check_eq("mid_rst_ram_en", {31'd0, ram_if.ram_en}, 32'd0);
      check_eq("mid_rst_ram_addr", {28'd0, ram_if.ram_addr}, 32'd0);
      check_eq("mid_rst_feed0", {16'd0, feed0}, 32'd0);
      check_eq("mid_rst_feed1", {16'd0, feed1}, 32'd0);
      check_eq("mid_rst_valid", {31'd0, feed_valid}, 32'd0);
      check_eq("mid_rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_stream(4'd6, 4'd1, 1'b0);
      ea = '{6, 7};        ec = '{2, 3};
      e0 = '{'h1111, 0};   e1 = '{0, 'h2222};
      compare_stream("post_rst", 3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
